// File: rtl/reg_file.sv
// Eight-entry register file with two combinational read ports, one write port and a zero flag.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to matching read ports.
module reg_file #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] read_reg1,
  input  logic [$clog2(NREGS)-1:0] read_reg2,
  output logic [WIDTH-1:0]         read_data1,
  output logic [WIDTH-1:0]         read_data2,
  input  logic                     reg_write,
  input  logic [$clog2(NREGS)-1:0] write_reg,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     flag_write,
  input  logic                     zero_in,
  output logic                     zero_flag
);

  localparam int AW = $clog2(NREGS);

  // R0 has no storage; it reads as zero and swallows writes.
  logic [WIDTH-1:0] regs_q [1:NREGS-1];
  logic [WIDTH-1:0] regs_d [1:NREGS-1];
  logic             zero_flag_q;
  logic             zero_flag_d;
  logic             wr_en_s;
  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;

  assign wr_en_s = reg_write && (write_reg != {AW{1'b0}});

  // Next-state for the register array and zero flag.
  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    zero_flag_d = zero_flag_q;
    if (wr_en_s) begin
      for (int i = 1; i < NREGS; i++) begin
        if (write_reg == AW'(i)) begin
          regs_d[i] = write_data;
        end else begin
          regs_d[i] = regs_q[i];
        end
      end
    end else begin
      zero_flag_d = zero_flag_q;
    end
    if (flag_write) begin
      zero_flag_d = zero_in;
    end else begin
      zero_flag_d = zero_flag_q;
    end
  end

  // State update; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= {WIDTH{1'b0}};
      end
      zero_flag_q <= 1'b0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      zero_flag_q <= zero_flag_d;
    end
  end

  // Read ports, with optional forwarding of the in-flight write.
  always_comb begin
    rd1_s = {WIDTH{1'b0}};
    rd2_s = {WIDTH{1'b0}};
    for (int i = 1; i < NREGS; i++) begin
      if (read_reg1 == AW'(i)) begin
        rd1_s = regs_q[i];
      end else begin
        rd1_s = rd1_s;
      end
      if (read_reg2 == AW'(i)) begin
        rd2_s = regs_q[i];
      end else begin
        rd2_s = rd2_s;
      end
    end
`ifdef REGFILE_BYPASS_EN
    if (!rst && wr_en_s && (write_reg == read_reg1)) begin
      rd1_s = write_data;
    end else begin
      rd1_s = rd1_s;
    end
    if (!rst && wr_en_s && (write_reg == read_reg2)) begin
      rd2_s = write_data;
    end else begin
      rd2_s = rd2_s;
    end
`else
    rd1_s = rd1_s;
    rd2_s = rd2_s;
`endif
  end

  assign read_data1 = rd1_s;
  assign read_data2 = rd2_s;
  assign zero_flag  = zero_flag_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file; each vector is checked just before the edge it is applied to.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [2:0]  read_reg1;
  logic [2:0]  read_reg2;
  logic [15:0] read_data1;
  logic [15:0] read_data2;
  logic        reg_write;
  logic [2:0]  write_reg;
  logic [15:0] write_data;
  logic        flag_write;
  logic        zero_in;
  logic        zero_flag;

  int n_tests;
  int n_fail;

  reg_file #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .flag_write(flag_write), .zero_in(zero_in), .zero_flag(zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rw;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        fw;
    logic        zi;
    logic [2:0]  a1;
    logic [2:0]  a2;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        ez;
    logic        chk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic rw, input logic [2:0] wr,
                              input logic [15:0] wd, input logic fw, input logic zi,
                              input logic [2:0] a1, input logic [2:0] a2,
                              input logic [15:0] e1, input logic [15:0] e2,
                              input logic ez, input logic chk);
    vec_t v;
    v.rst = r; v.rw = rw; v.wr = wr; v.wd = wd; v.fw = fw; v.zi = zi;
    v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.ez = ez; v.chk = chk;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; reg_write = v.rw; write_reg = v.wr; write_data = v.wd;
    flag_write = v.fw; zero_in = v.zi; read_reg1 = v.a1; read_reg2 = v.a2;
  endtask

  initial begin
    vec_t v;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; reg_write = 1'b0; write_reg = 3'd0; write_data = 16'h0000;
    flag_write = 1'b0; zero_in = 1'b0; read_reg1 = 3'd0; read_reg2 = 3'd0;

    //            rst   rw    wr    wd        fw    zi    a1    a2    e1        e2        ez    chk
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'(i), 3'(7 - i), 16'h0000, 16'h0000, 1'b0, 1'b1));
    end
    vecs.push_back(mk(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 3'd5, 16'hFFFF, 1'b0, 1'b0, 3'd3, 3'd0, 16'h1234, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 3'd0, 16'hBEEF, 1'b0, 1'b0, 3'd3, 3'd5, 16'h1234, 16'hFFFF, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 3'd2, 16'h00AA, 1'b0, 1'b0, 3'd1, 3'd1, 16'h0000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b1, 3'd2, 16'h5555, 1'b0, 1'b0, 3'd2, 3'd3,
                      BYP ? 16'h5555 : 16'h00AA, 16'h1234, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd2, 3'd2, 16'h5555, 16'h5555, 1'b0, 1'b1));
    // Reset together with writes: forwarding is suppressed, everything clears.
    vecs.push_back(mk(1'b1, 1'b1, 3'd4, 16'h7777, 1'b1, 1'b1, 3'd4, 3'd2, 16'h0000, 16'h5555, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd4, 3'd2, 16'h0000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd3, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1));
    end
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd6, 16'hCAFE, 1'b0, 1'b0, 3'd6, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd6, 3'd6, 16'h0000, 16'h0000, 1'b0, 1'b1));
    // Register write and flag capture in the same cycle.
    vecs.push_back(mk(1'b0, 1'b1, 3'd7, 16'h0F0F, 1'b1, 1'b1, 3'd7, 3'd1,
                      BYP ? 16'h0F0F : 16'h0000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd7, 3'd7, 16'h0F0F, 16'h0F0F, 1'b1, 1'b1));

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      if (vecs[k].chk) begin
        check($sformatf("vec%0d rd1", k), read_data1, vecs[k].e1);
        check($sformatf("vec%0d rd2", k), read_data2, vecs[k].e2);
        check($sformatf("vec%0d zflag", k), {15'd0, zero_flag}, {15'd0, vecs[k].ez});
      end
    end

    // Hold: a written value survives several idle cycles with junk on the write bus.
    @(negedge clk);
    rst = 1'b0; reg_write = 1'b1; write_reg = 3'd6; write_data = 16'hA5A5;
    flag_write = 1'b0; read_reg1 = 3'd6; read_reg2 = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      reg_write = 1'b0; write_data = 16'h1111 * 16'(c + 1);
      #1;
      check($sformatf("hold%0d rd1", c), read_data1, 16'hA5A5);
      check($sformatf("hold%0d rd2", c), read_data2, 16'h0000);
    end

    // Mid-program reset discards R6 and R7.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; read_reg1 = 3'd6; read_reg2 = 3'd7;
    #1;
    check("midrst rd1", read_data1, 16'h0000);
    check("midrst rd2", read_data2, 16'h0000);
    check("midrst zflag", {15'd0, zero_flag}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
